tri_row_collector: RTL
======================

# tri_row_collector

Collects the de-skewed rows leaving the triangular output FIFO of the systolic array and hands them to the output-buffer writer over a valid/ready interface. A row is taken only when every lane presents data in the same cycle. Each accepted row is stored in a small circular row buffer, tagged with its row index within the tile, and the last row is flagged. The block also tracks tile progress and reports misaligned or overflowing input, because the upstream FIFO cannot be back-pressured.

## Interface
- BIT_WIDTH, 32, width of one lane element
- TRI_LENGTH, 16, number of lanes (row width in elements)
- ROW_DEPTH, 4, row buffer entries (power of two, ≥2)
- ROW_COUNT, 16, rows per tile (≥2)
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse to begin a tile; honoured only in IDLE
- enable_in  input  [TRI_LENGTH]  per-lane valid from the de-skew FIFO
- data_in  input  [TRI_LENGTH][BIT_WIDTH]  per-lane data from the de-skew FIFO
- out_valid  output  1  buffer head holds a row
- out_ready  input  1  consumer accepts the head row
- out_data  output  [TRI_LENGTH][BIT_WIDTH]  head row
- out_row_idx  output  $clog2(ROW_COUNT)  tile row index of the head row
- out_last  output  1  head row is row ROW_COUNT-1
- busy  output  1  high in COLLECT and DRAIN
- done  output  1  one-cycle pulse when a tile completes
- err_misalign  output  1  sticky; partial-enable cycle seen in COLLECT
- err_overflow  output  1  sticky; row dropped because the buffer was full

## Operation
- The FSM has four states: IDLE, COLLECT, DRAIN, DONE.
- **IDLE**
  - start moves to COLLECT.
  - The same edge clears the row counter, the buffer pointers, err_misalign and err_overflow.
  - enable_in is ignored in IDLE; no flag is raised.
- **COLLECT**
  - A full row is a cycle with all enable_in bits set. It is pushed with tag = current row counter, and the counter increments.
  - A partial row is a cycle with some, but not all, enable_in bits set. It sets err_misalign, pushes nothing, and leaves the counter unchanged.
  - When the counter reaches ROW_COUNT, the FSM moves to DRAIN on the same edge that accepts that row.
- **Overflow**
  - A full row arriving while the buffer is full with no pop in that cycle is dropped and sets err_overflow.
  - The row counter still increments, so the tile terminates; the missing index appears as a gap in out_row_idx.
  - A push and a pop in the same cycle while full is legal: the push succeeds and occupancy is unchanged.
- **DRAIN**
  - enable_in is ignored.
  - When the buffer is empty, the FSM moves to DONE.
- **DONE**
  - done=1 for exactly one cycle, then the FSM returns to IDLE.
  - Sticky errors hold until the next start.
- **Pop**: a pop occurs when out_valid && out_ready. out_data, out_row_idx and out_last must stay stable while out_valid=1 and out_ready=0.
- **Buffer pointers**: read/write pointers are $clog2(ROW_DEPTH)+1 bits wide and wrap modulo 2·ROW_DEPTH.
  - Full when the MSBs differ and the low bits are equal.
  - Empty when the pointers are equal.
- out_last = (out_row_idx == ROW_COUNT-1) && out_valid.
- start outside IDLE is ignored.

## Timing
- **Reset**
  - Asynchronous, active-high; takes effect immediately, including mid-tile.
  - Returns the FSM to IDLE and discards all buffered rows.
  - All outputs read 0: out_valid, out_data, out_row_idx, out_last, busy, done, err_misalign, err_overflow.
- **start → busy**: start sampled at edge N gives busy=1 from N+1.
- **Push latency**: a row pushed at edge N into an empty buffer gives out_valid=1 after edge N, with that row on out_data. Latency is 1 cycle and there is no combinational path from enable_in to out_valid.
- **Throughput**: one row per cycle in and one row per cycle out.
- **End of tile**
  - The final pop at edge M (buffer becomes empty) puts the FSM in DRAIN after M.
  - The next edge M+1 enters DONE, with done=1 during M+1..M+2.
  - busy falls at M+1.
  - If the last row is pushed into a buffer that is already empty and it is popped at once, the same sequence applies after its pop.
- **Error flags**: err_misalign and err_overflow assert on the edge following the offending cycle.

## Test plan
- **Streaming tile**: reset, start, 16 consecutive full rows with data_in[i]=row*16+i, out_ready=1.
  - Required: 16 pops, out_row_idx 0..15 in order, out_last only on idx 15, done one cycle, no errors.
- **Back-pressure**: ROW_DEPTH=4, out_ready=0 while rows 0..3 are pushed, then out_ready=1.
  - Required: out_valid held with row 0 stable.
  - Required: rows 0..3 then delivered intact, err_overflow=0.
- **Overflow**: out_ready=0, push 5 rows.
  - Required: row 4 dropped and err_overflow=1.
  - Required: after release, idx 0..3 delivered, then 5..15 as they arrive; done still pulses.
- **Full plus simultaneous pop**: buffer full; in one cycle push row 4 while popping row 0.
  - Required: row 4 accepted, no overflow.
- **Misalignment**: a cycle with enable_in=16'h7FFF in COLLECT.
  - Required: err_misalign=1 next cycle, no push, counter unchanged.
  - Required: the tile still completes after 16 full rows.
- **Reset mid-tile**: assert rst after row 7 is pushed with 3 rows buffered.
  - Required: all outputs 0 immediately and FSM in IDLE.
  - Required: a new start runs a clean tile from idx 0.

Source files
------------

// File: rtl/tri_row_collector.sv
// Collects full rows from the triangular de-skew FIFO into a small circular buffer
// and presents them, tagged with their tile row index, on a valid/ready port.
//
// state   | meaning
// IDLE    | waiting for start; inputs ignored
// COLLECT | accepting full rows until ROW_COUNT have arrived
// DRAIN   | inputs ignored; emptying the row buffer
// DONE    | one-cycle done pulse, then back to IDLE
module tri_row_collector #(
  parameter int BIT_WIDTH  = 32,
  parameter int TRI_LENGTH = 16,
  parameter int ROW_DEPTH  = 4,
  parameter int ROW_COUNT  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [TRI_LENGTH-1:0]                enable_in,
  input  logic [TRI_LENGTH-1:0][BIT_WIDTH-1:0] data_in,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [TRI_LENGTH-1:0][BIT_WIDTH-1:0] out_data,
  output logic [$clog2(ROW_COUNT)-1:0]         out_row_idx,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err_misalign,
  output logic                                 err_overflow
);

  localparam int IDX_W = $clog2(ROW_COUNT);
  localparam int CNT_W = IDX_W + 1;
  localparam int AW    = $clog2(ROW_DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROW_COUNT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_COUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] row_cnt_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             buf_full, buf_empty;
  logic             in_collect, all_en, any_en;
  logic             pop, push, start_tile, last_row_in;

  logic [TRI_LENGTH-1:0][BIT_WIDTH-1:0] data_mem [ROW_DEPTH];
  logic [IDX_W-1:0]                     idx_mem  [ROW_DEPTH];

  assign buf_empty = (wr_ptr_q == rd_ptr_q);
  assign buf_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign in_collect  = (state_q == S_COLLECT);
  assign all_en      = &enable_in;
  assign any_en      = |enable_in;
  assign pop         = out_valid && out_ready;
  // A simultaneous pop frees the slot this push lands in.
  assign push        = in_collect && all_en && (!buf_full || pop);
  assign start_tile  = (state_q == S_IDLE) && start;
  assign last_row_in = in_collect && all_en && (row_cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_COLLECT;
      S_COLLECT: if (last_row_in) state_d = S_DRAIN;
      S_DRAIN:   if (buf_empty) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_misalign <= 1'b0;
      err_overflow <= 1'b0;
    end else if (start_tile) begin
      row_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_misalign <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      // Dropped rows still advance the count so the tile always terminates.
      if (in_collect && all_en) row_cnt_q <= row_cnt_q + CNT_W'(1);
      if (in_collect && any_en && !all_en) err_misalign <= 1'b1;
      if (in_collect && all_en && buf_full && !pop) err_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q[AW-1:0]] <= data_in;
      idx_mem[wr_ptr_q[AW-1:0]]  <= row_cnt_q[IDX_W-1:0];
    end
  end

  assign out_valid   = !buf_empty;
  assign out_data    = out_valid ? data_mem[rd_ptr_q[AW-1:0]] : '0;
  assign out_row_idx = out_valid ? idx_mem[rd_ptr_q[AW-1:0]] : '0;
  assign out_last    = out_valid && (out_row_idx == LAST_IDX);
  assign busy        = (state_q == S_COLLECT) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);

endmodule
